// File: rtl/serial_subtractor16_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor16.
// Optional overflow flag V exists only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor16_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             Bi;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             Bo;
`ifdef SUB_OVERFLOW_EN
   logic             V;

   modport master (
      output start, X, Y, Bi,
      input  busy, done, D, Bo, V
   );
   modport slave (
      input  start, X, Y, Bi,
      output busy, done, D, Bo, V
   );
`else
   modport master (
      output start, X, Y, Bi,
      input  busy, done, D, Bo
   );
   modport slave (
      input  start, X, Y, Bi,
      output busy, done, D, Bo
   );
`endif
endinterface

// File: rtl/serial_subtractor16.sv
// Bit-serial D = X - Y - Bi, LSB first, one bit per clock.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output V.
module serial_subtractor16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor16_if.slave bus
);
   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] xs;
   logic [WIDTH-1:0] ys;
   logic [WIDTH-1:0] rs;
   logic             b;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             fin;
   logic             s;
   logic             b_nx;
   logic             done_q;
   logic [WIDTH-1:0] d_q;
   logic             bo_q;

   assign s    = xs[0] ^ ys[0] ^ b;
   assign b_nx = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               fin     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         xs      <= '0;
         ys      <= '0;
         rs      <= '0;
         b       <= 1'b0;
         cnt     <= '0;
         done_q  <= 1'b0;
         d_q     <= '0;
         bo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= fin;
         if (load) begin
            xs  <= bus.X;
            ys  <= bus.Y;
            b   <= bus.Bi;
            cnt <= '0;
         end else if (state_q == RUN) begin
            xs  <= xs >> 1;
            ys  <= ys >> 1;
            b   <= b_nx;
            rs  <= {s, rs[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
         end
         if (fin) begin
            d_q  <= {s, rs[WIDTH-1:1]};
            bo_q <= b_nx;
         end
      end
   end

`ifdef SUB_OVERFLOW_EN
   logic v_q;

   // On the last bit xs[0]/ys[0] are the operand sign bits and s is D's sign
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
      end else if (fin) begin
         v_q <= (xs[0] ^ ys[0]) & (s ^ xs[0]);
      end
   end

   assign bus.V = v_q;
`endif

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.D    = d_q;
   assign bus.Bo   = bo_q;
endmodule
